// File: rtl/ddr3_bridge_defines_pkg.sv
// Shared definitions for the DDR3 user bridge and any ddr3_controller
// wrapper that needs to decode the bridge state or address width.
package ddr3_bridge_defines_pkg;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_GRAB  = 3'd1,
        WR_FILL  = 3'd2,
        WR_FLUSH = 3'd3,
        RD_GRAB  = 3'd4,
        RD_DATA  = 3'd5,
        RD_STOP  = 3'd6
    } bridge_state_e;

endpackage

// File: rtl/ddr3_user_bridge.sv
// Bridges word-count read/write requests onto a ping-pong inbound FIFO
// (writes toward DDR3) and a single outbound FIFO (reads from DDR3).
// Writes are split into FIFO-sized fills; reads into FIFO-sized drains.
module ddr3_user_bridge
    import ddr3_bridge_defines_pkg::*;
#(
    parameter int CNT_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_address,
    input  logic [CNT_W-1:0]  req_count,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] write_address,
    output logic              write_en,
    output logic [ADDR_W-1:0] read_address,
    output logic              read_en,
    output logic              if_write_strobe,
    output logic [DATA_W-1:0] if_write_data,
    input  logic [1:0]        if_write_ready,
    output logic [1:0]        if_write_activate,
    input  logic [CNT_W-1:0]  if_write_fifo_size,
    input  logic              if_starved,
    output logic              of_read_strobe,
    input  logic              of_read_ready,
    output logic              of_read_activate,
    input  logic [CNT_W-1:0]  of_read_size,
    input  logic [DATA_W-1:0] of_read_data
);

    bridge_state_e     state_q;
    logic              ready_en_q;     // low until the first edge after reset release
    logic [ADDR_W-1:0] write_address_q;
    logic [ADDR_W-1:0] read_address_q;
    logic              write_en_q;
    logic              read_en_q;
    logic [1:0]        wr_act_q;
    logic              rd_act_q;
    logic              done_q;
    logic [CNT_W-1:0]  remaining_q;
    logic [CNT_W-1:0]  fill_q;         // words written into the current inbound buffer
    logic [CNT_W-1:0]  rcount_q;       // words taken from the current outbound grab

    logic wr_room;
    logic rd_room;

    // A data beat may move only while the current buffer has room and words remain.
    assign wr_room = (fill_q < if_write_fifo_size) && (remaining_q != '0);
    assign rd_room = (rcount_q < of_read_size) && (remaining_q != '0);

    assign req_ready         = (state_q == IDLE) && ready_en_q;
    assign wdata_ready       = (state_q == WR_FILL) && wr_room;
    assign if_write_strobe   = wdata_valid && wdata_ready;
    assign if_write_data     = wdata;
    assign rdata             = of_read_data;
    assign rdata_valid       = (state_q == RD_DATA) && rd_room;
    assign of_read_strobe    = rdata_valid && rdata_ready;
    assign busy              = (state_q != IDLE);
    assign done              = done_q;
    assign write_address     = write_address_q;
    assign read_address      = read_address_q;
    assign write_en          = write_en_q;
    assign read_en           = read_en_q;
    assign if_write_activate = wr_act_q;
    assign of_read_activate  = rd_act_q;

    // Transfer sequencer: request accept, FIFO grab/fill/drain, completion pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            ready_en_q      <= 1'b0;
            write_address_q <= '0;
            read_address_q  <= '0;
            write_en_q      <= 1'b0;
            read_en_q       <= 1'b0;
            wr_act_q        <= 2'b00;
            rd_act_q        <= 1'b0;
            done_q          <= 1'b0;
            remaining_q     <= '0;
            fill_q          <= '0;
            rcount_q        <= '0;
        end else begin
            ready_en_q <= 1'b1;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        if (req_count == '0) begin
                            // Empty request completes immediately without touching the controller.
                            done_q <= 1'b1;
                        end else if (req_write) begin
                            write_address_q <= req_address;
                            remaining_q     <= req_count;
                            write_en_q      <= 1'b1;
                            state_q         <= WR_GRAB;
                        end else begin
                            read_address_q <= req_address;
                            remaining_q    <= req_count;
                            read_en_q      <= 1'b1;
                            state_q        <= RD_GRAB;
                        end
                    end
                end
                WR_GRAB: begin
                    // Prefer buffer 0 whenever it is free.
                    if ((if_write_ready != 2'b00) && (wr_act_q == 2'b00)) begin
                        wr_act_q <= if_write_ready[0] ? 2'b01 : 2'b10;
                        fill_q   <= '0;
                        state_q  <= WR_FILL;
                    end
                end
                WR_FILL: begin
                    if (if_write_strobe) begin
                        fill_q      <= fill_q + CNT_W'(1);
                        remaining_q <= remaining_q - CNT_W'(1);
                    end else if (!wr_room) begin
                        // Buffer full or request exhausted: hand the buffer to the controller.
                        wr_act_q <= 2'b00;
                        if (remaining_q != '0) begin
                            state_q <= WR_GRAB;
                        end else begin
                            write_en_q <= 1'b0;
                            state_q    <= WR_FLUSH;
                        end
                    end
                end
                WR_FLUSH: begin
                    // Completion waits until the controller has drained both buffers.
                    if (if_starved) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                RD_GRAB: begin
                    if (of_read_ready && !rd_act_q) begin
                        rd_act_q <= 1'b1;
                        rcount_q <= '0;
                        state_q  <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (of_read_strobe) begin
                        rcount_q    <= rcount_q + CNT_W'(1);
                        remaining_q <= remaining_q - CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) begin
                            // Last word: stop the controller; any prefetched surplus is dropped.
                            read_en_q <= 1'b0;
                            rd_act_q  <= 1'b0;
                            state_q   <= RD_STOP;
                        end else if ((rcount_q + CNT_W'(1)) >= of_read_size) begin
                            rd_act_q <= 1'b0;
                            state_q  <= RD_GRAB;
                        end
                    end
                end
                RD_STOP: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
